pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter W, default 16, bit width of one data lane.
REQ-002 Parameter L, default 4, number of data lanes (lane 0 = upper, 1 = lower, 2 = word, 3 = byte-zero-extended in the EX/MEM instance).
REQ-003 Parameter C, default 3, control field width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-low.
REQ-006 Port flush  input  1  discard all held entries (branch/exception squash).
REQ-007 Port in_valid  input  1  upstream presents a beat.
REQ-008 Port in_ready  output  1  stage accepts a beat this cycle; registered output.
REQ-009 Port in_data  input  L*W  lane k at bits [k*W +: W].
REQ-010 Port in_ctrl  input  C  control bits travelling with the beat.
REQ-011 Port out_valid  output  1  stage presents a beat downstream.
REQ-012 Port out_ready  input  1  downstream accepts the beat.
REQ-013 Port out_data  output  L*W  data of the presented beat.
REQ-014 Port out_ctrl  output  C  control of the presented beat.
REQ-015 Port stall_cnt  output  16  stall statistics (present only with the configuration macro, REQ-032).

Function
REQ-016 Storage SHALL be two entries, main and skid, each L*W data + C ctrl; state machine EMPTY, ONE (main valid), TWO (main+skid valid).
REQ-017 A beat SHALL transfer in when in_valid && in_ready at a rising edge, and out when out_valid && out_ready.
REQ-018 out_valid SHALL equal 1 in ONE and TWO, 0 in EMPTY; out_data/out_ctrl SHALL be driven from main combinationally.
REQ-019 in_ready SHALL be a register, 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-020 EMPTY: accept -> ONE, main loaded; no accept -> stay.
REQ-021 ONE: accept and send -> ONE, main reloaded; accept only -> TWO, skid loaded; send only -> EMPTY; neither -> stay.
REQ-022 TWO: send -> ONE, skid moved into main; no send -> stay, both entries hold.
REQ-023 Latency in->out SHALL be one cycle; throughput one beat/cycle when out_ready stays high.
REQ-024 Beat order SHALL be preserved; no beat duplicated or dropped except by flush.
REQ-025 Data and ctrl held in an entry SHALL not change while that entry is valid and not moved.
REQ-026 flush SHALL, at the edge, force state EMPTY, in_ready 1, and ignore any in_valid/out_ready transfer that cycle; data contents are don't-care.
REQ-027 flush and rst low together: rst SHALL take priority; result identical.

Reset
REQ-028 With rst low at a rising edge: state EMPTY, out_valid 0, in_ready 1, main and skid data/ctrl all zero, out_data 0, out_ctrl 0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; the first beat after release SHALL be accepted in the first cycle rst is high.
REQ-030 No asynchronous behaviour on rst; rst changes between edges SHALL have no effect.

Configuration
REQ-031 Macro PIPE_STAGE_BUF_STATS_EN SHALL select the statistics feature.
REQ-032 Defined: stall_cnt port exists; increments by 1 each edge with out_valid && !out_ready, saturates at 16'hFFFF, cleared by reset and by flush.
REQ-033 Undefined: stall_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-034 Reset: rst low 2 cycles with in_valid=1 in_data=all 0xA5A5 lanes -> out_valid 0, in_ready 1, out_data 0 after release.
REQ-035 Streaming: 8 beats data k=1..8 in consecutive cycles, out_ready=1 -> out_data k appears cycle k+1, out_valid continuous, in_ready always 1.
REQ-036 Backpressure: out_ready=0 while sending beats 0x1111, 0x2222, 0x3333 -> state TWO after 2 beats, in_ready 0, third beat held upstream; out_ready=1 -> 0x1111, 0x2222, 0x3333 in order, none lost.
REQ-037 Flush: state TWO, flush=1 with in_valid=1 data 0x4444 -> next cycle out_valid 0, in_ready 1, 0x4444 never emitted.
REQ-038 Reset mid-operation: state TWO, rst low one cycle -> EMPTY, out_valid 0; next beat 0x5555 out one cycle after acceptance.
REQ-039 Stats (macro defined): out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt 16'hFFFF; flush -> stall_cnt 0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: two-entry (main + skid) pipeline register with a registered in_ready.
// Optional stall statistics counter enabled by defining PIPE_STAGE_BUF_STATS_EN.
`default_nettype none

module pipe_stage_buf #(
  parameter int W = 16,
  parameter int L = 4,
  parameter int C = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [L*W-1:0]   in_data,
  input  logic [C-1:0]     in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [L*W-1:0]   out_data,
  output logic [C-1:0]     out_ctrl
`ifdef PIPE_STAGE_BUF_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [L*W-1:0]     main_data;
  logic [L*W-1:0]     skid_data;
  logic [C-1:0]       main_ctrl;
  logic [C-1:0]       skid_ctrl;
  logic               ready_q;
  logic               accept;
  logic               send;
  logic               load_main_in;
  logic               load_main_skid;
  logic               load_skid_in;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign in_ready  = ready_q;
  assign accept    = in_valid && ready_q;
  assign send      = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && send) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt    = TWO;
          load_skid_in = 1'b1;
        end else if (send) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (send) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A squash overrides every transfer decided above.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      ready_q   <= 1'b1;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state   <= state_nxt;
      // Ready is derived from the next state so it never depends on out_ready combinationally.
      ready_q <= (state_nxt != TWO);
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid_in) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: randomized + directed scoreboard bench for pipe_stage_buf.
`default_nettype none

module tb_pipe_stage_buf;

  localparam int W = 16;
  localparam int L = 4;
  localparam int C = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [L*W-1:0]   in_data = '0;
  logic [C-1:0]     in_ctrl = '0;
  logic             in_ready;
  logic             out_valid;
  logic [L*W-1:0]   out_data;
  logic [C-1:0]     out_ctrl;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  pipe_stage_buf #(.W(W), .L(L), .C(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [L*W-1:0] d;
    logic [C-1:0]   c;
  } beat_t;

  beat_t sb[$];          // beats held by the stage, oldest first
  int    checks = 0;
  int    fails = 0;
  bit    armed = 1'b0;
  bit    zero_exp = 1'b0;
  bit    acc;
  int    stall_model = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the reference, then advance the reference over the coming edge.
  always @(negedge clk) begin
    if (armed) begin
      check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      if (sb.size() > 0) begin
        check("out_data", 64'(out_data), 64'(sb[0].d));
        check("out_ctrl", 64'(out_ctrl), 64'(sb[0].c));
      end else if (zero_exp) begin
        check("out_data_zero", 64'(out_data), 64'd0);
        check("out_ctrl_zero", 64'(out_ctrl), 64'd0);
      end
`ifdef PIPE_STAGE_BUF_STATS_EN
      check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
`endif
    end
    if (!rst) begin
      sb.delete();
      armed       = 1'b1;
      zero_exp    = 1'b1;
      stall_model = 0;
    end else if (armed) begin
      if (flush) begin
        sb.delete();
        zero_exp    = 1'b0;
        stall_model = 0;
      end else begin
        if (sb.size() > 0 && !out_ready && stall_model < 65535) stall_model++;
        acc = in_valid && (sb.size() < 2);
        if (sb.size() > 0 && out_ready) void'(sb.pop_front());
        if (acc) begin
          sb.push_back('{d: in_data, c: in_ctrl});
          zero_exp = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] v, input logic [C-1:0] c);
    in_valid = 1'b1;
    in_data  = {L{v}};
    in_ctrl  = c;
  endtask

  initial begin
    // Reset with a beat pending upstream: nothing may be captured.
    rst = 1'b0;
    beat(16'hA5A5, 3'b101);
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();

    // Streaming k = 1..8 back to back.
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      beat(16'(k), 3'(k));
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Backpressure: fill both entries, hold the third beat upstream.
    out_ready = 1'b0;
    beat(16'h1111, 3'd1);
    tick();
    beat(16'h2222, 3'd2);
    tick();
    beat(16'h3333, 3'd3);
    repeat (3) tick();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!in_ready && n < 10) begin
        tick();
        n++;
      end
      check("bp_wait_bound", 64'(n < 10), 64'd1);
    end
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // Flush from TWO with a beat offered in the same cycle.
    out_ready = 1'b0;
    beat(16'h1234, 3'd4);
    tick();
    beat(16'h2345, 3'd5);
    tick();
    flush = 1'b1;
    beat(16'h4444, 3'd6);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (3) tick();

    // Reset in the middle of operation, then a fresh beat.
    out_ready = 1'b0;
    beat(16'h6666, 3'd1);
    tick();
    beat(16'h7777, 3'd2);
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    beat(16'h5555, 3'd7);
    tick();
    in_valid = 1'b0;
    check("rst_5555_out", 64'(out_data), 64'({L{16'h5555}}));
    out_ready = 1'b1;
    repeat (3) tick();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = {$urandom, $urandom};
      in_ctrl   = C'($urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      rst       = ($urandom % 150) != 0;
      tick();
    end
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

`ifdef PIPE_STAGE_BUF_STATS_EN
    // Long stall to saturate the counter, then flush clears it.
    out_ready = 1'b0;
    beat(16'h9999, 3'd3);
    tick();
    in_valid = 1'b0;
    repeat (70000) tick();
    check("stall_sat", 64'(stall_cnt), 64'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stall_flush", 64'(stall_cnt), 64'd0);
    out_ready = 1'b1;
    repeat (2) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
